acorn128_decrypt_process: RTL and testbench

Bit-serial ACORN-128 decryption stage. It runs after associated-data absorption and before finalization/tag generation. Starting from the 293-bit state left by AD processing, it consumes one ciphertext bit per handshake and emits the matching plaintext bit. It feeds each plaintext bit back into the state as the message bit, then runs the 256-cycle message padding phase and hands the final state on to finalization.

---
 rtl/acorn128_pkg.sv | 38 +++
 rtl/acorn128_step.sv | 39 +++
 rtl/acorn128_decrypt_process.sv | 137 +++++++++++++
 tb/tb_acorn128_decrypt_process.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acorn128_pkg.sv
// Shared constants, tap positions, boolean helpers and FSM encoding for the
// bit-serial ACORN-128 datapath blocks.
package acorn128_pkg;

    localparam int unsigned STATE_W     = 293;
    localparam int unsigned PAD_LEN     = 256;
    localparam int unsigned CA_PAD_LAST = 127;

    // LFSR feedbacks: S[DST] ^= S[A] ^ S[B], applied in order 0..5,
    // each one seeing the bits already updated by the previous ones.
    localparam int unsigned FB0_DST = 289, FB0_A = 235, FB0_B = 230;
    localparam int unsigned FB1_DST = 230, FB1_A = 196, FB1_B = 193;
    localparam int unsigned FB2_DST = 193, FB2_A = 160, FB2_B = 154;
    localparam int unsigned FB3_DST = 154, FB3_A = 111, FB3_B = 107;
    localparam int unsigned FB4_DST = 107, FB4_A = 66,  FB4_B = 61;
    localparam int unsigned FB5_DST = 61,  FB5_A = 23,  FB5_B = 0;

    // Keystream taps
    localparam int unsigned KS_L0 = 12,  KS_L1 = 154;
    localparam int unsigned KS_MX = 235, KS_MY = 61,  KS_MZ = 193;
    localparam int unsigned KS_CX = 230, KS_CY = 111, KS_CZ = 66;

    // Feedback-bit taps
    localparam int unsigned F_L0 = 0,   F_NL = 107;
    localparam int unsigned F_MX = 244, F_MY = 23, F_MZ = 160;
    localparam int unsigned F_CA = 196;

    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic ch(input logic x, input logic y, input logic z);
        return (x & y) ^ (~x & z);
    endfunction

    typedef enum logic [1:0] {IDLE, MSG, PAD, DONE} state_t;

endpackage

// File: rtl/acorn128_step.sv
// One ACORN-128 state update: in-place LFSR feedbacks, keystream bit,
// feedback bit and a one-position shift. Purely combinational.
module acorn128_step
    import acorn128_pkg::*;
(
    input  logic [STATE_W-1:0] i_s,
    input  logic               i_m,
    input  logic               i_ca,
    input  logic               i_cb,
    output logic [STATE_W-1:0] o_s_next,
    output logic               o_ks
);

    logic [STATE_W-1:0] w_t;
    logic               w_f;

    // Feedbacks and keystream; independent of i_m so callers may derive m from ks.
    always_comb begin
        w_t = i_s;
        w_t[FB0_DST] = w_t[FB0_DST] ^ w_t[FB0_A] ^ w_t[FB0_B];
        w_t[FB1_DST] = w_t[FB1_DST] ^ w_t[FB1_A] ^ w_t[FB1_B];
        w_t[FB2_DST] = w_t[FB2_DST] ^ w_t[FB2_A] ^ w_t[FB2_B];
        w_t[FB3_DST] = w_t[FB3_DST] ^ w_t[FB3_A] ^ w_t[FB3_B];
        w_t[FB4_DST] = w_t[FB4_DST] ^ w_t[FB4_A] ^ w_t[FB4_B];
        w_t[FB5_DST] = w_t[FB5_DST] ^ w_t[FB5_A] ^ w_t[FB5_B];
        o_ks = w_t[KS_L0] ^ w_t[KS_L1]
             ^ maj(w_t[KS_MX], w_t[KS_MY], w_t[KS_MZ])
             ^ ch(w_t[KS_CX], w_t[KS_CY], w_t[KS_CZ]);
    end

    // Feedback bit and shift into the top of the state.
    always_comb begin
        w_f = w_t[F_L0] ^ ~w_t[F_NL]
            ^ maj(w_t[F_MX], w_t[F_MY], w_t[F_MZ])
            ^ (i_ca & w_t[F_CA]) ^ (i_cb & o_ks) ^ i_m;
        o_s_next = {w_f, w_t[STATE_W-1:1]};
    end

endmodule

// File: rtl/acorn128_decrypt_process.sv
// Bit-serial ACORN-128 decryption stage: ciphertext handshake phase, fixed
// 256-step padding phase, then a one-cycle done with the final state.
module acorn128_decrypt_process
    import acorn128_pkg::*;
#(
    parameter int unsigned MSG_LEN = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [STATE_W-1:0] state_in,
    input  logic               c_bit,
    input  logic               c_valid,
    output logic               c_ready,
    output logic               p_bit,
    output logic               p_valid,
    output logic               busy,
    output logic               done,
    output logic [STATE_W-1:0] state_out
);

    localparam int unsigned      CNT_W    = $clog2(PAD_LEN) + 1;
    localparam logic [CNT_W-1:0] MSG_LAST = CNT_W'(MSG_LEN - 1);
    localparam logic [CNT_W-1:0] PAD_LAST = CNT_W'(PAD_LEN - 1);
    localparam logic [CNT_W-1:0] CA_LAST  = CNT_W'(CA_PAD_LAST);

    state_t             r_state, w_state_d;
    logic [STATE_W-1:0] r_s, w_s_d, w_s_step;
    logic [STATE_W-1:0] r_state_out, w_state_out_d;
    logic [CNT_W-1:0]   r_cnt, w_cnt_d;
    logic               r_p_bit, w_p_bit_d;
    logic               r_p_valid, w_p_valid_d;
    logic               w_ks, w_p, w_m, w_ca;

    acorn128_step u_step (
        .i_s      (r_s),
        .i_m      (w_m),
        .i_ca     (w_ca),
        .i_cb     (1'b0),
        .o_s_next (w_s_step),
        .o_ks     (w_ks)
    );

    // Step controls per phase; kept apart from next-state logic so the m<-ks path has no loop.
    always_comb begin
        w_p  = c_bit ^ w_ks;
        w_m  = 1'b0;
        w_ca = 1'b0;
        case (r_state)
            MSG: begin
                w_m  = w_p;
                w_ca = 1'b1;
            end
            PAD: begin
                w_m  = (r_cnt == '0);
                w_ca = (r_cnt <= CA_LAST);
            end
            default: ;
        endcase
    end

    // Next-state and datapath decisions.
    always_comb begin
        w_state_d     = r_state;
        w_s_d         = r_s;
        w_cnt_d       = r_cnt;
        w_p_bit_d     = r_p_bit;
        w_p_valid_d   = 1'b0;
        w_state_out_d = r_state_out;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_s_d     = state_in;
                    w_cnt_d   = '0;
                    w_state_d = (MSG_LEN == 0) ? PAD : MSG;
                end else if (r_state == DONE) begin
                    w_state_d = IDLE;
                end
            end
            MSG: begin
                if (c_valid) begin
                    w_s_d       = w_s_step;
                    w_p_bit_d   = w_p;
                    w_p_valid_d = 1'b1;
                    if (r_cnt == MSG_LAST) begin
                        w_cnt_d   = '0;
                        w_state_d = PAD;
                    end else begin
                        w_cnt_d = r_cnt + 1'b1;
                    end
                end
            end
            PAD: begin
                w_s_d = w_s_step;
                if (r_cnt == PAD_LAST) begin
                    w_cnt_d       = '0;
                    w_state_d     = DONE;
                    w_state_out_d = w_s_step;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_d;
    end

    // Datapath registers: cipher state, counter, plaintext output, final state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s         <= '0;
            r_cnt       <= '0;
            r_p_bit     <= 1'b0;
            r_p_valid   <= 1'b0;
            r_state_out <= '0;
        end else begin
            r_s         <= w_s_d;
            r_cnt       <= w_cnt_d;
            r_p_bit     <= w_p_bit_d;
            r_p_valid   <= w_p_valid_d;
            r_state_out <= w_state_out_d;
        end
    end

    assign c_ready   = (r_state == MSG);
    assign busy      = (r_state == MSG) || (r_state == PAD);
    assign done      = (r_state == DONE);
    assign p_bit     = r_p_bit;
    assign p_valid   = r_p_valid;
    assign state_out = r_state_out;

endmodule

// File: tb/tb_acorn128_decrypt_process.sv
// Scoreboard bench for acorn128_decrypt_process: three builds (128-, 4- and
// 0-bit messages) driven with random vectors against an ACORN reference model.
module tb_acorn128_decrypt_process;

    localparam int unsigned LEN [3] = '{128, 4, 0};

    logic         clk;
    logic         rst;
    logic         start_s  [3];
    logic [292:0] sin_s    [3];
    logic         cbit_s   [3];
    logic         cval_s   [3];
    logic         cready_s [3];
    logic         pbit_s   [3];
    logic         pval_s   [3];
    logic         busy_s   [3];
    logic         done_s   [3];
    logic [292:0] sout_s   [3];

    int           vectors     = 0;
    int           miscompares = 0;
    bit           exp_p     [$];
    logic [292:0] exp_state [$];
    int           active  = 0;
    bit           hs_flag = 0;
    bit           hs_prev = 0;
    bit           mon_exp_pv;
    bit           mon_e;
    bit           g_ct [128];

    acorn128_decrypt_process #(.MSG_LEN(128)) u_dut_128 (
        .clk(clk), .rst(rst), .start(start_s[0]), .state_in(sin_s[0]),
        .c_bit(cbit_s[0]), .c_valid(cval_s[0]), .c_ready(cready_s[0]),
        .p_bit(pbit_s[0]), .p_valid(pval_s[0]), .busy(busy_s[0]),
        .done(done_s[0]), .state_out(sout_s[0])
    );

    acorn128_decrypt_process #(.MSG_LEN(4)) u_dut_4 (
        .clk(clk), .rst(rst), .start(start_s[1]), .state_in(sin_s[1]),
        .c_bit(cbit_s[1]), .c_valid(cval_s[1]), .c_ready(cready_s[1]),
        .p_bit(pbit_s[1]), .p_valid(pval_s[1]), .busy(busy_s[1]),
        .done(done_s[1]), .state_out(sout_s[1])
    );

    acorn128_decrypt_process #(.MSG_LEN(0)) u_dut_0 (
        .clk(clk), .rst(rst), .start(start_s[2]), .state_in(sin_s[2]),
        .c_bit(cbit_s[2]), .c_valid(cval_s[2]), .c_ready(cready_s[2]),
        .p_bit(pbit_s[2]), .p_valid(pval_s[2]), .busy(busy_s[2]),
        .done(done_s[2]), .state_out(sout_s[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [292:0] act, input logic [292:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [292:0] rand293();
        logic [292:0] r;
        r = '0;
        for (int i = 0; i < 10; i++) r = (r << 32) | 293'($urandom());
        return r;
    endfunction

    function automatic bit maj3(input bit a, input bit b, input bit c);
        return (int'(a) + int'(b) + int'(c)) >= 2;
    endfunction

    // Reference ACORN-128 state update written straight from the algorithm.
    function automatic logic [292:0] model_step(input logic [292:0] s, input bit m,
                                                input bit ca, input bit cb, output bit ks);
        logic [292:0] t;
        bit           f;
        t = s;
        t[289] = t[289] ^ t[235] ^ t[230];
        t[230] = t[230] ^ t[196] ^ t[193];
        t[193] = t[193] ^ t[160] ^ t[154];
        t[154] = t[154] ^ t[111] ^ t[107];
        t[107] = t[107] ^ t[66]  ^ t[61];
        t[61]  = t[61]  ^ t[23]  ^ t[0];
        ks = t[12] ^ t[154] ^ maj3(t[235], t[61], t[193]) ^ (t[230] ? t[111] : t[66]);
        f  = t[0] ^ !t[107] ^ maj3(t[244], t[23], t[160]) ^ (ca & t[196]) ^ (cb & ks) ^ m;
        t = t >> 1;
        t[292] = f;
        return t;
    endfunction

    function automatic logic [292:0] model_pad(input logic [292:0] s);
        bit ks;
        for (int j = 0; j < 256; j++) s = model_step(s, j == 0, j < 128, 1'b0, ks);
        return s;
    endfunction

    task automatic apply_mid_reset(input int d);
        #1 rst = 1'b0;
        #1;
        check("rst_c_ready",   cready_s[d], 0);
        check("rst_p_bit",     pbit_s[d],   0);
        check("rst_p_valid",   pval_s[d],   0);
        check("rst_busy",      busy_s[d],   0);
        check("rst_done",      done_s[d],   0);
        check("rst_state_out", sout_s[d],   0);
        exp_p.delete();
        exp_state.delete();
        hs_flag   = 1'b0;
        cval_s[d] = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One full operation on build d; expected outputs are queued before driving.
    task automatic run_op(input int d, input logic [292:0] st, input bit fixed,
                          input bit bp, input bit inj, input int rst_at);
        int           n, idx, iters, k, busy_cnt;
        logic [292:0] s, tmp;
        bit           ks, p, cv;
        n = int'(LEN[d]);
        s = st;
        for (int i = 0; i < n; i++) begin
            tmp = model_step(s, 1'b0, 1'b1, 1'b0, ks);
            p = fixed ? (g_ct[i] ^ ks) : 1'($urandom_range(0, 1));
            g_ct[i] = p ^ ks;
            exp_p.push_back(p);
            s = model_step(s, p, 1'b1, 1'b0, ks);
        end
        exp_state.push_back(model_pad(s));

        active      = d;
        hs_flag     = 1'b0;
        start_s[d]  = 1'b1;
        sin_s[d]    = st;
        cval_s[d]   = 1'($urandom_range(0, 1));
        cbit_s[d]   = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        start_s[d] = 1'b0;
        sin_s[d]   = rand293();
        busy_cnt   = int'(busy_s[d]);
        if (n > 0) begin
            check("c_ready_after_start", cready_s[d], 1);
        end else begin
            check("c_ready_len0", cready_s[d], 0);
            check("busy_after_start", busy_s[d], 1);
        end

        idx   = 0;
        iters = 0;
        while (idx < n && iters < 4000) begin
            cv = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            cval_s[d] = cv;
            cbit_s[d] = g_ct[idx];
            hs_flag   = cv;
            if (inj && cv && idx == n / 2) begin
                start_s[d] = 1'b1;
                sin_s[d]   = rand293();
            end
            check("c_ready_msg", cready_s[d], 1);
            @(posedge clk);
            #1;
            start_s[d] = 1'b0;
            iters++;
            busy_cnt += int'(busy_s[d]);
            if (cv) idx++;
            if (cv && rst_at >= 0 && idx == rst_at) begin
                apply_mid_reset(d);
                return;
            end
        end
        if (idx < n) check("msg_budget", idx, n);

        hs_flag = 1'b0;
        k = 0;
        while (k < 300) begin
            cval_s[d]  = 1'($urandom_range(0, 1));
            cbit_s[d]  = 1'($urandom_range(0, 1));
            start_s[d] = inj && (k == 150);
            if (start_s[d]) sin_s[d] = rand293();
            @(posedge clk);
            #1;
            start_s[d] = 1'b0;
            k++;
            busy_cnt += int'(busy_s[d]);
            if (done_s[d]) break;
            check("c_ready_pad", cready_s[d], 0);
        end
        check("done_latency", k, 256);
        check("busy_cycles", busy_cnt, iters + 256);
        cval_s[d] = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int d = 0; d < 3; d++) begin
            start_s[d] = 1'b0;
            cval_s[d]  = 1'b0;
        end
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every p_valid pops one expected plaintext bit, every done one final state.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            mon_exp_pv = (d == active) && hs_prev && rst;
            if (pval_s[d] || mon_exp_pv) begin
                check("p_valid", pval_s[d], mon_exp_pv);
                if (pval_s[d] && mon_exp_pv) begin
                    if (exp_p.size() == 0) begin
                        check("p_queue", pval_s[d], 0);
                    end else begin
                        mon_e = exp_p.pop_front();
                        check("p_bit", pbit_s[d], mon_e);
                    end
                end
            end
            if (done_s[d]) begin
                if (exp_state.size() == 0) check("unexpected_done", done_s[d], 0);
                else check("state_out", sout_s[d], exp_state.pop_front());
            end
        end
        hs_prev = hs_flag && rst;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [292:0] st_a;
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            start_s[d] = 1'b0;
            sin_s[d]   = '0;
            cbit_s[d]  = 1'b0;
            cval_s[d]  = 1'b0;
        end
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check("reset_c_ready",   cready_s[d], 0);
            check("reset_p_bit",     pbit_s[d],   0);
            check("reset_p_valid",   pval_s[d],   0);
            check("reset_busy",      busy_s[d],   0);
            check("reset_done",      done_s[d],   0);
            check("reset_state_out", sout_s[d],   0);
        end
        #2 rst = 1'b1;
        idle(2);

        // Zero state, 4-bit message 1,0,1,1 with continuous valid.
        g_ct[0] = 1'b1; g_ct[1] = 1'b0; g_ct[2] = 1'b1; g_ct[3] = 1'b1;
        run_op(1, '0, 1'b1, 1'b0, 1'b0, -1);
        idle(3);

        // Round trip, then the same ciphertext under back-pressure.
        st_a = rand293();
        run_op(0, st_a, 1'b0, 1'b0, 1'b0, -1);
        idle(2);
        run_op(0, st_a, 1'b1, 1'b1, 1'b0, -1);
        idle(2);

        // Reset at handshake 60, then a fresh run.
        run_op(0, rand293(), 1'b0, 1'b0, 1'b0, 60);
        idle(2);
        run_op(0, rand293(), 1'b0, 1'b0, 1'b0, -1);
        idle(2);

        // Stray starts in MSG and PAD, then back-to-back runs started in DONE.
        run_op(0, rand293(), 1'b0, 1'b0, 1'b1, -1);
        run_op(0, rand293(), 1'b0, 1'b0, 1'b0, -1);
        run_op(0, rand293(), 1'b0, 1'b1, 1'b0, -1);
        idle(2);

        // Empty-message build.
        run_op(2, rand293(), 1'b0, 1'b0, 1'b0, -1);
        run_op(2, rand293(), 1'b0, 1'b0, 1'b1, -1);
        idle(2);

        // Short build with back-pressure.
        run_op(1, rand293(), 1'b0, 1'b1, 1'b0, -1);
        idle(3);

        check("p_pending",     exp_p.size(),     0);
        check("state_pending", exp_state.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
